// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl
// Sequencer that lets a debug/test host read or write the whole register file
// over valid/ready streams.
//   Dump: walks read port 1 over x0..x(NREGS-1) and streams each word out on
//         m_data/m_valid/m_ready.
//   Load: accepts NREGS words on s_data/s_valid/s_ready and writes them to
//         x0..x(NREGS-1) through the write port.
// While busy is low, the datapath owns the register file ports. An external
// mux selects between the datapath and this block using busy.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, mode       one-cycle request taken in IDLE; mode 0 = dump, 1 = load
//   busy, done        operation in progress / one-cycle completion pulse
//   rf_a1, rf_rd1     register file read port 1 (rd1 is combinational from a1)
//   rf_a3, rf_wd3,
//   rf_we3            register file write port
//   m_data, m_valid,
//   m_ready           dump stream source
//   s_data, s_valid,
//   s_ready           load stream sink
//   checksum          (only with RFDUMP_CHECKSUM_EN) XOR of every streamed word
//
// Optional build macro: RFDUMP_CHECKSUM_EN adds the checksum output.
module regfile_dump_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_a1,
    input  logic [DW-1:0] rf_rd1,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3,
    output logic          rf_we3,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready
`ifdef RFDUMP_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DUMP  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] LOAD  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    // One extra bit so that NREGS = 2^AW can be counted without wrapping.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

    logic [2:0]  state;
    logic [AW:0] idx;

    logic start_acc;
    logic dump_adv;
    logic load_acc;

    assign start_acc = (state == IDLE) && start;
    // The output register may take a new word when it is empty or being drained.
    assign dump_adv  = (state == DUMP) && (!m_valid || m_ready);
    assign load_acc  = (state == LOAD) && s_valid && s_ready;

    // The read address follows the walk index directly, so rf_rd1 for word idx
    // is captured into m_data on the same cycle the index is presented.
    assign rf_a1 = (state == DUMP) ? idx[AW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            s_ready <= 1'b0;
            rf_a3   <= '0;
            rf_wd3  <= '0;
            rf_we3  <= 1'b0;
        end else begin
            done   <= 1'b0;
            rf_we3 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        busy    <= 1'b1;
                        s_ready <= mode;
                        state   <= mode ? LOAD : DUMP;
                    end
                end
                DUMP: begin
                    if (dump_adv) begin
                        m_data  <= rf_rd1;
                        m_valid <= 1'b1;
                        idx     <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last word is sitting in the output register.
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOAD: begin
                    if (load_acc) begin
                        rf_a3  <= idx[AW-1:0];
                        rf_wd3 <= s_data;
                        rf_we3 <= 1'b1;
                        idx    <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            s_ready <= 1'b0;
                            state   <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // rf_we3 for the final word is high this cycle; the write
                    // lands on this edge, so done can follow immediately.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RFDUMP_CHECKSUM_EN
    // Words are folded in when captured into m_data; every captured word is
    // eventually emitted, so the value is complete by the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (dump_adv) begin
            checksum <= checksum ^ rf_rd1;
        end else if (load_acc) begin
            checksum <= checksum ^ s_data;
        end
    end
`else
    // Without the checksum, the start strobe is only used by the FSM.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Testbench for regfile_dump_ctrl: random stall/gap stimulus with a
// behavioural register file and expected-contents model.
module tb_regfile_dump_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, mode;
    logic          busy, done;
    logic [AW-1:0] rf_a1, rf_a3;
    logic [DW-1:0] rf_rd1, rf_wd3;
    logic          rf_we3;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
`ifdef RFDUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    regfile_dump_ctrl #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy), .done(done),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1),
        .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
`ifdef RFDUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Register file environment: x0 reads zero, writes land on the clock edge,
    // and reset reloads the preload pattern xN = 0x1000_0000 + N.
    logic [DW-1:0] rf [NREGS];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NREGS; n++) rf[n] <= 32'h1000_0000 + n;
        end else if (rf_we3 && rf_a3 != 0) begin
            rf[rf_a3] <= rf_wd3;
        end
    end
    assign rf_rd1 = (rf_a1 == 0) ? '0 : rf[rf_a1];

    // Expected register file contents as seen through a dump.
    logic [DW-1:0] exp_rf [NREGS];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitors, sampled on the falling edge.
    int            cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] dq[$];
    logic [DW-1:0] wq_data[$];
    logic [AW-1:0] wq_addr[$];
    int            done_cnt = 0;
    int            t_start, t_first, t_last_hs, t_done;
    bit            first_seen = 1'b1;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                t_start    = cyc;
                first_seen = 1'b0;
            end
            if (m_valid && !first_seen) begin
                t_first    = cyc;
                first_seen = 1'b1;
            end
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                dq.push_back(m_data);
                t_last_hs = cyc;
            end
            if (rf_we3) begin
                wq_addr.push_back(rf_a3);
                wq_data.push_back(rf_wd3);
            end
            if (done) begin
                done_cnt++;
                t_done = cyc;
            end
        end
    end

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_m_valid"}, m_valid, 0);
        check({pfx, "_s_ready"}, s_ready, 0);
        check({pfx, "_rf_we3"}, rf_we3, 0);
        check({pfx, "_rf_a1"}, rf_a1, 0);
        check({pfx, "_rf_a3"}, rf_a3, 0);
        check({pfx, "_rf_wd3"}, rf_wd3, 0);
        check({pfx, "_m_data"}, m_data, 0);
    endtask

    // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic run_dump(input int rmode);
        int base;
        int n;
        logic [DW-1:0] xs;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        dq.delete();
        base = done_cnt;
        @(posedge clk); #1;
        check("dump_idle_busy", busy, 0);
        start = 1'b1; mode = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("dump_busy_after_start", busy, 1);
        n = 0;
        while (done_cnt == base && n < 2000) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[n % 4];
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("dump_done_count", done_cnt - base, 1);
        check("dump_busy_end", busy, 0);
        check("dump_beats", dq.size(), NREGS);
        xs = '0;
        for (int i = 0; i < NREGS; i++) begin
            xs ^= exp_rf[i];
            if (i < dq.size()) check($sformatf("dump_x%0d_m%0d", i, rmode), dq[i], exp_rf[i]);
        end
        if (rmode == 0) begin
            check("dump_first_valid_latency", t_first - t_start, 2);
            check("dump_burst_length", t_last_hs - t_first, NREGS - 1);
            check("dump_done_latency", t_done - t_last_hs, 1);
        end
`ifdef RFDUMP_CHECKSUM_EN
        check("dump_checksum", checksum, xs);
`endif
    endtask

    initial begin
        int base;
        int k;
        int n;
        bit hs;
        logic [DW-1:0] xs;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; m_ready = 1'b0;
        s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < NREGS; i++) exp_rf[i] = (i == 0) ? '0 : 32'h1000_0000 + i;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a dump.
        @(posedge clk); #1;
        dq.delete();
        start = 1'b1; mode = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (dq.size() < 7 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_dump_m_data", m_data, exp_rf[7]);
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_done", done_cnt - base, 0);

        run_dump(0);
        run_dump(1);
        run_dump(2);

        // Load with random gaps, a stray start mid-operation, and surplus beats.
        wq_addr.delete();
        wq_data.delete();
        base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0;
        check("load_busy", busy, 1);
        check("load_s_ready_first", s_ready, 1);
        k = 0; n = 0; hs = 1'b0;
        while (done_cnt == base && n < 2000) begin
            if (hs) k++;
            s_valid = (k >= NREGS) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_data  = 32'hA5A5_0000 + k;
            start   = (n == 10);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0; s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("load_done_count", done_cnt - base, 1);
        check("load_busy_end", busy, 0);
        check("load_write_count", wq_addr.size(), NREGS);
        xs = '0;
        for (int i = 0; i < NREGS; i++) begin
            xs ^= 32'hA5A5_0000 + i;
            if (i < wq_addr.size()) begin
                check($sformatf("load_addr_%0d", i), wq_addr[i], i);
                check($sformatf("load_data_%0d", i), wq_data[i], 32'hA5A5_0000 + i);
            end
            exp_rf[i] = (i == 0) ? '0 : 32'hA5A5_0000 + i;
        end
`ifdef RFDUMP_CHECKSUM_EN
        check("load_checksum", checksum, xs);
`endif

        // Read back what the load wrote.
        run_dump(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
